pc_fetch_unit: RTL and testbench

//  Upstream neighbour of the main decoder: holds the PC, fetches one 32-bit instruction per

---
 rtl/mips_pkg.sv | 20 ++
 rtl/next_pc_calc.sv | 32 +++
 rtl/pc_fetch_unit.sv | 96 +++++++++
 tb/tb_pc_fetch_unit.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared encodings for the fetch front end: next-PC select codes, opcodes and fetch FSM states.
package mips_pkg;

  localparam logic [1:0] PCSRC_SEQ  = 2'b00;
  localparam logic [1:0] PCSRC_JUMP = 2'b01;
  localparam logic [1:0] PCSRC_REG  = 2'b10;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    EXEC  = 2'd2,
    HALT  = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/next_pc_calc.sv
// Combinational next-PC selection: sequential/branch, jump, register target.
module next_pc_calc
  import mips_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [25:0] jumpIndex,
  input  logic [1:0]  PCSrc,
  input  logic        Branch,
  input  logic        Zero,
  input  logic [31:0] imm_ext,
  input  logic [31:0] ra_data,
  output logic [31:0] pcPlus4,
  output logic [31:0] nextPc
);

  logic [31:0] branchTarget;

  assign pcPlus4      = pc + 32'd4;
  assign branchTarget = pcPlus4 + (imm_ext << 2);

  always_comb begin
    nextPc = pcPlus4;
    case (PCSrc)
      PCSRC_SEQ:  if (Branch && Zero) nextPc = branchTarget;
      PCSRC_JUMP: nextPc = {pcPlus4[31:28], jumpIndex, 2'b00};
      // Register targets are forced word-aligned rather than trapping.
      PCSRC_REG:  nextPc = ra_data & ~32'h3;
      default:    nextPc = pcPlus4;
    endcase
  end

endmodule

// File: rtl/pc_fetch_unit.sv
// PC register, instruction register and fetch FSM feeding the main decoder.
module pc_fetch_unit
  import mips_pkg::*;
#(
  parameter logic [31:0] PC_RESET = 32'h0000_0000,
  parameter logic [7:0]  TIMEOUT  = 8'd255
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic [1:0]  PCSrc,
  input  logic        Branch,
  input  logic        Zero,
  input  logic [31:0] imm_ext,
  input  logic [31:0] ra_data,
  output logic [31:0] instr,
  output logic [5:0]  OpCode,
  output logic [5:0]  Funct,
  output logic        instr_valid,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        fetch_err
);

  fetch_state_t stateReg;
  logic [7:0]   timeoutCnt;
  logic [31:0]  nextPc;
  logic         timeoutHit;

  next_pc_calc u_nextPcCalc (
    .pc        (pc),
    .jumpIndex (instr[25:0]),
    .PCSrc     (PCSrc),
    .Branch    (Branch),
    .Zero      (Zero),
    .imm_ext   (imm_ext),
    .ra_data   (ra_data),
    .pcPlus4   (pc_plus4),
    .nextPc    (nextPc)
  );

  assign imem_addr = pc;
  assign OpCode    = instr[31:26];
  assign Funct     = instr[5:0];
  // This FETCH cycle is the TIMEOUT-th one without an ack.
  assign timeoutHit = ({1'b0, timeoutCnt} + 9'd1) >= {1'b0, TIMEOUT};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stateReg    <= BOOT;
      pc          <= PC_RESET;
      instr       <= '0;
      imem_req    <= 1'b0;
      instr_valid <= 1'b0;
      fetch_err   <= 1'b0;
      timeoutCnt  <= '0;
    end else begin
      case (stateReg)
        BOOT: begin
          stateReg   <= FETCH;
          imem_req   <= 1'b1;
          timeoutCnt <= '0;
        end
        FETCH: begin
          if (imem_ack) begin
            instr       <= imem_rdata;
            imem_req    <= 1'b0;
            instr_valid <= 1'b1;
            stateReg    <= EXEC;
          end else if (timeoutHit) begin
            fetch_err <= 1'b1;
            imem_req  <= 1'b0;
            stateReg  <= HALT;
          end else begin
            timeoutCnt <= timeoutCnt + 8'd1;
          end
        end
        EXEC: begin
          if (!stall) begin
            pc          <= nextPc;
            instr_valid <= 1'b0;
            imem_req    <= 1'b1;
            timeoutCnt  <= '0;
            stateReg    <= FETCH;
          end
        end
        default: stateReg <= HALT;
      endcase
    end
  end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit; expected fetch addresses flow through a scoreboard queue.
module tb_pc_fetch_unit;
  import mips_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        stall;
  logic [1:0]  PCSrc;
  logic        Branch;
  logic        Zero;
  logic [31:0] imm_ext;
  logic [31:0] ra_data;
  logic [31:0] instr;
  logic [5:0]  OpCode;
  logic [5:0]  Funct;
  logic        instr_valid;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        fetch_err;

  int total = 0;
  int bad = 0;
  logic [31:0] expQ[$];
  logic [31:0] lastInstr;
  logic [31:0] expAddr;

  always #5 clk = ~clk;

  pc_fetch_unit #(.PC_RESET(32'h0000_0000), .TIMEOUT(8'd4)) dut (
    .clk         (clk),
    .reset       (reset),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .stall       (stall),
    .PCSrc       (PCSrc),
    .Branch      (Branch),
    .Zero        (Zero),
    .imm_ext     (imm_ext),
    .ra_data     (ra_data),
    .instr       (instr),
    .OpCode      (OpCode),
    .Funct       (Funct),
    .instr_valid (instr_valid),
    .pc          (pc),
    .pc_plus4    (pc_plus4),
    .fetch_err   (fetch_err)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One instruction slot: fetch with ackDelay wait cycles, optional stall, then commit.
  task automatic fetchExec(input logic [31:0] rdata, input int ackDelay, input int stallCyc,
                           input logic [1:0] src, input logic br, input logic zr,
                           input logic [31:0] imm, input logic [31:0] ra,
                           input logic [31:0] expNext);
    logic [31:0] addr;
    int reqCycles;
    for (int n = 0; n < 10 && imem_req !== 1'b1; n++) tick();
    chk("req_rise", {31'b0, imem_req}, 32'd1);
    addr = (expQ.size() > 0) ? expQ.pop_front() : 32'hBAD0_BAD0;
    chk("fetch_addr", imem_addr, addr);
    reqCycles = 1;
    for (int d = 0; d < ackDelay; d++) begin
      tick();
      if (imem_req === 1'b1) reqCycles++;
      chk("addr_stable", imem_addr, addr);
    end
    chk("req_cycles", reqCycles, ackDelay + 1);
    imem_rdata = rdata;
    imem_ack   = 1'b1;
    tick();
    imem_ack   = 1'b0;
    imem_rdata = '0;
    chk("exec_valid", {31'b0, instr_valid}, 32'd1);
    chk("exec_req", {31'b0, imem_req}, 32'd0);
    chk("exec_instr", instr, rdata);
    chk("exec_opcode", {26'b0, OpCode}, {26'b0, rdata[31:26]});
    chk("exec_funct", {26'b0, Funct}, {26'b0, rdata[5:0]});
    chk("exec_pc", pc, addr);
    chk("exec_pc4", pc_plus4, addr + 32'd4);
    PCSrc = src; Branch = br; Zero = zr; imm_ext = imm; ra_data = ra;
    for (int s = 0; s < stallCyc; s++) begin
      stall      = 1'b1;
      imem_ack   = 1'b1;
      imem_rdata = ~rdata;
      tick();
      chk("stall_instr", instr, rdata);
      chk("stall_pc", pc, addr);
      chk("stall_valid", {31'b0, instr_valid}, 32'd1);
      chk("stall_req", {31'b0, imem_req}, 32'd0);
    end
    stall      = 1'b0;
    imem_ack   = 1'b0;
    imem_rdata = '0;
    expQ.push_back(expNext);
    $display("slot pc=%h ir=%h src=%b br=%b z=%b next=%h", addr, rdata, src, br, zr, expNext);
    tick();
    PCSrc = PCSRC_SEQ; Branch = 1'b0; Zero = 1'b0; imm_ext = '0; ra_data = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b0; imem_ack = 1'b0; imem_rdata = '0; stall = 1'b0;
    PCSrc = PCSRC_SEQ; Branch = 1'b0; Zero = 1'b0; imm_ext = '0; ra_data = '0;
    repeat (2) tick();
    chk("rst_req", {31'b0, imem_req}, 32'd0);
    chk("rst_valid", {31'b0, instr_valid}, 32'd0);
    chk("rst_err", {31'b0, fetch_err}, 32'd0);
    chk("rst_pc", pc, 32'h0);
    chk("rst_instr", instr, 32'h0);

    reset = 1'b1;
    expQ.push_back(32'h0);
    fetchExec(32'h0000_0020, 0, 0, PCSRC_SEQ,  1'b0, 1'b0, 32'h0,         32'h0,         32'h0000_0004);
    fetchExec(32'h0000_0020, 3, 2, PCSRC_SEQ,  1'b0, 1'b0, 32'h0,         32'h0,         32'h0000_0008);
    fetchExec(32'h0000_0020, 1, 0, PCSRC_SEQ,  1'b1, 1'b0, 32'h0000_0010, 32'h0,         32'h0000_000C);
    fetchExec(32'h0000_0020, 0, 0, PCSRC_SEQ,  1'b0, 1'b0, 32'h0,         32'h0,         32'h0000_0010);
    fetchExec(32'h1000_FFFE, 0, 0, PCSRC_SEQ,  1'b1, 1'b1, 32'hFFFF_FFFE, 32'h0,         32'h0000_000C);
    fetchExec(32'h1000_FFFE, 2, 0, PCSRC_SEQ,  1'b1, 1'b0, 32'hFFFF_FFFE, 32'h0,         32'h0000_0010);
    fetchExec(32'h0810_0000, 0, 1, PCSRC_JUMP, 1'b1, 1'b1, 32'h0000_0004, 32'h0,         32'h0040_0000);
    fetchExec(32'h0800_0010, 0, 0, PCSRC_JUMP, 1'b0, 1'b0, 32'h0,         32'h0,         32'h0000_0040);
    fetchExec(32'h03E0_0008, 0, 0, PCSRC_REG,  1'b0, 1'b0, 32'h0,         32'h0000_0123, 32'h0000_0120);
    fetchExec(32'h0000_0020, 0, 0, 2'b11,      1'b1, 1'b1, 32'h0000_0100, 32'h0000_0800, 32'h0000_0124);
    fetchExec(32'h03E0_0008, 0, 0, PCSRC_REG,  1'b0, 1'b0, 32'h0,         32'hFFFF_FFFF, 32'hFFFF_FFFC);
    lastInstr = 32'h0000_0020;
    fetchExec(lastInstr,     0, 0, PCSRC_SEQ,  1'b0, 1'b0, 32'h0,         32'h0,         32'h0000_0000);

    // Never acknowledge: four FETCH cycles then sticky error and HALT.
    expAddr = (expQ.size() > 0) ? expQ.pop_front() : 32'hBAD0_BAD0;
    chk("to_addr", imem_addr, expAddr);
    chk("to_req0", {31'b0, imem_req}, 32'd1);
    repeat (3) tick();
    chk("to_err_early", {31'b0, fetch_err}, 32'd0);
    chk("to_req3", {31'b0, imem_req}, 32'd1);
    tick();
    chk("to_err", {31'b0, fetch_err}, 32'd1);
    chk("to_req_drop", {31'b0, imem_req}, 32'd0);
    chk("to_valid", {31'b0, instr_valid}, 32'd0);
    imem_ack = 1'b1; imem_rdata = 32'h1234_5678;
    repeat (3) tick();
    chk("halt_err", {31'b0, fetch_err}, 32'd1);
    chk("halt_req", {31'b0, imem_req}, 32'd0);
    chk("halt_instr", instr, lastInstr);
    chk("halt_valid", {31'b0, instr_valid}, 32'd0);
    imem_ack = 1'b0; imem_rdata = '0;
    $display("slot timeout pc=%h fetch_err=%b", pc, fetch_err);

    reset = 1'b0;
    #1;
    chk("rst2_err", {31'b0, fetch_err}, 32'd0);
    chk("rst2_pc", pc, 32'h0);
    tick();
    reset = 1'b1;
    expQ.push_back(32'h0);
    fetchExec(32'h0000_0020, 0, 0, PCSRC_SEQ, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0000_0004);

    // Reset in the middle of a FETCH at pc=4, with an ack arriving across the release.
    expAddr = (expQ.size() > 0) ? expQ.pop_front() : 32'hBAD0_BAD0;
    chk("mid_addr", imem_addr, expAddr);
    tick();
    #2;
    reset = 1'b0;
    #1;
    chk("mid_req_async", {31'b0, imem_req}, 32'd0);
    chk("mid_pc", pc, 32'h0);
    imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    tick();
    reset = 1'b1;
    tick();
    chk("late_ack_instr", instr, 32'h0);
    chk("late_ack_valid", {31'b0, instr_valid}, 32'd0);
    chk("late_ack_req", {31'b0, imem_req}, 32'd1);
    imem_ack = 1'b0; imem_rdata = '0;
    $display("slot reset mid-fetch pc=%h req=%b", pc, imem_req);
    expQ.push_back(32'h0);
    fetchExec(32'h0000_0020, 1, 0, PCSRC_SEQ, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0000_0004);

    expAddr = (expQ.size() > 0) ? expQ.pop_front() : 32'hBAD0_BAD0;
    chk("final_addr", imem_addr, expAddr);
    chk("sb_empty", expQ.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
